// File: rtl/z80_dbg_pkg.sv
// z80_dbg_pkg: shared types and constants for the Z80 debug blocks
package z80_dbg_pkg;
  typedef enum logic [1:0] {RUN, HALTED, STEP} bp_state_t;
  localparam int MAX_BP = 8;
  localparam int FLAG_C = 0;
  localparam int FLAG_P = 2;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;
  // 16-bit register fields on the debugger register bus
  localparam int REG_AF = 0;
  localparam int REG_BC = 16;
  localparam int REG_DE = 32;
  localparam int REG_HL = 48;
  localparam int REG_IX = 64;
  localparam int REG_IY = 80;
  localparam int REG_SP = 96;
  localparam int REG_PC = 112;
endpackage

// File: rtl/z80_bp_match.sv
// z80_bp_match: breakpoint comparator array with lowest-index priority encoder
module z80_bp_match
  import z80_dbg_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic [15:0]          cpu_addr,
  input  logic [NUM_BP*16-1:0] bp_addr,
  input  logic [NUM_BP-1:0]    bp_en,
  output logic                 any_hit,
  output logic [2:0]           hit_idx
);
  always_comb begin
    any_hit = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_en[i] && cpu_addr == bp_addr[16*i +: 16]) begin
        any_hit = 1'b1;
        hit_idx = 3'(i);
      end
  end
endmodule

// File: rtl/z80_breakpoint.sv
// z80_breakpoint: holds the T80 in opcode fetch on breakpoints, halt requests and single-step
module z80_breakpoint
  import z80_dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 m1_n,
  input  logic [15:0]          cpu_addr,
  input  logic [NUM_BP*16-1:0] bp_addr,
  input  logic [NUM_BP-1:0]    bp_en,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 run_req,
  output logic                 wait_n,
  output logic                 halted,
  output logic                 hit_valid,
  output logic [2:0]           hit_idx,
  output logic [15:0]          halt_pc,
  output logic [CNT_W-1:0]     fetch_cnt
);
  bp_state_t state, state_nxt;
  logic m1_q, m1_fall, halt_pend, capture, any_hit;
  logic [2:0] match_idx;
  assign m1_fall = ce & ~m1_n & m1_q;
  assign halted = state == HALTED;
  z80_bp_match #(.NUM_BP(NUM_BP)) u_match (
    .cpu_addr(cpu_addr),
    .bp_addr(bp_addr),
    .bp_en(bp_en),
    .any_hit(any_hit),
    .hit_idx(match_idx)
  );
  always_comb begin
    state_nxt = state;
    capture = 1'b0;
    case (state)
      RUN: if (m1_fall && (any_hit || halt_pend)) begin
        state_nxt = HALTED;
        capture = 1'b1;
      end
      HALTED: state_nxt = run_req ? RUN : step_req ? STEP : HALTED;
      STEP: if (run_req) state_nxt = RUN;
      else if (m1_fall) begin
        state_nxt = HALTED;
        capture = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end
  // leaving HALTED always drops hit_valid; it is only raised again by a capture
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= RUN;
      m1_q      <= 1'b1;
      halt_pend <= 1'b0;
      wait_n    <= 1'b1;
      hit_valid <= 1'b0;
      hit_idx   <= 3'd0;
      halt_pc   <= 16'd0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_n    <= state_nxt != HALTED;
      hit_valid <= capture ? any_hit : hit_valid & (state_nxt == HALTED);
      halt_pend <= capture ? 1'b0 : halt_pend | (halt_req & (state != HALTED));
      if (ce) m1_q <= m1_n;
      if (m1_fall) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (capture) begin
        hit_idx <= match_idx;
        halt_pc <= cpu_addr;
      end
    end
  end
endmodule

// File: tb/tb_z80_breakpoint.sv
// tb_z80_breakpoint: randomized run-control checks against a transaction-level model
module tb_z80_breakpoint;
  localparam int NUM_BP = 4;
  localparam int CNT_W  = 4;
  logic clk_sys = 1'b0, reset_n = 1'b0, ce = 1'b0, m1_n = 1'b1;
  logic halt_req = 1'b0, step_req = 1'b0, run_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [NUM_BP*16-1:0] bp_addr = '0;
  logic [NUM_BP-1:0] bp_en = '0;
  logic wait_n, halted, hit_valid;
  logic [2:0] hit_idx;
  logic [15:0] halt_pc;
  logic [CNT_W-1:0] fetch_cnt;
  int vectors = 0, errors = 0;
  bit m_held, m_step, m_pend, m_hv;
  int m_idx, m_cnt;
  logic [15:0] m_pc;

  always #5 clk_sys = ~clk_sys;

  z80_breakpoint #(.NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .m1_n(m1_n), .cpu_addr(cpu_addr),
    .bp_addr(bp_addr), .bp_en(bp_en), .halt_req(halt_req), .step_req(step_req),
    .run_req(run_req), .wait_n(wait_n), .halted(halted), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .halt_pc(halt_pc), .fetch_cnt(fetch_cnt)
  );

  function automatic logic [25:0] observed();
    return {wait_n, halted, hit_valid, hit_idx, halt_pc, fetch_cnt};
  endfunction

  function automatic logic [25:0] expected();
    return {~m_held, m_held, m_hv, 3'(m_idx), m_pc, 4'(m_cnt)};
  endfunction

  function automatic int lowest_hit(input logic [15:0] a);
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && bp_addr[16*i +: 16] == a) return i;
    return -1;
  endfunction

  task automatic wait_ce();
    int k = 0;
    do begin
      ce = (k >= 3) ? 1'b1 : 1'($urandom);
      k++;
      @(negedge clk_sys);
    end while (!ce);
  endtask

  task automatic fetch(input logic [15:0] a);
    int h;
    m1_n = 1'b1;
    wait_ce();
    cpu_addr = a;
    m1_n = 1'b0;
    wait_ce();
    ce = 1'b0;
    h = lowest_hit(a);
    m_cnt = (m_cnt + 1) % 16;
    if (!m_held && (m_step || m_pend || h >= 0)) begin
      m_held = 1'b1;
      m_step = 1'b0;
      m_pend = 1'b0;
      m_pc = a;
      m_hv = h >= 0;
      m_idx = h >= 0 ? h : 0;
    end
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL fetch %h: got %h want %h", a, observed(), expected());
    end
  endtask

  task automatic cmd(input bit r, input bit s, input bit h);
    run_req = r;
    step_req = s;
    halt_req = h;
    ce = 1'($urandom);
    @(negedge clk_sys);
    run_req = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    ce = 1'b0;
    if (m_held) begin
      if (r || s) begin
        m_held = 1'b0;
        m_hv = 1'b0;
        m_step = !r;
      end
    end else begin
      if (h) m_pend = 1'b1;
      if (r) m_step = 1'b0;
    end
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL cmd r%0d s%0d h%0d: got %h want %h", r, s, h, observed(), expected());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'($urandom);
      @(negedge clk_sys);
    end
    ce = 1'b0;
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL idle: got %h want %h", observed(), expected());
    end
  endtask

  task automatic do_reset(input string tag);
    m1_n = 1'b1;
    reset_n = 1'b0;
    ce = 1'($urandom);
    @(negedge clk_sys);
    reset_n = 1'b1;
    ce = 1'b0;
    {m_held, m_step, m_pend, m_hv} = '0;
    m_idx = 0;
    m_cnt = 0;
    m_pc = '0;
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, observed(), expected());
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
    idle(4);
  endtask

  task automatic test_bp_hit();
    bp_addr[15:0] = 16'h0100;
    bp_en = 4'b0001;
    fetch(16'h00FE);
    fetch(16'h00FF);
    fetch(16'h0100);
    vectors++;
    if ({wait_n, hit_valid, hit_idx, halt_pc, fetch_cnt} !== {1'b0, 1'b1, 3'd0, 16'h0100, 4'd3}) begin
      errors++;
      $display("FAIL bp_hit: got %h want %h", {wait_n, hit_valid, hit_idx, halt_pc, fetch_cnt},
               {1'b0, 1'b1, 3'd0, 16'h0100, 4'd3});
    end
    idle(5);
  endtask

  task automatic test_step();
    cmd(1'b0, 1'b1, 1'b0);
    fetch(16'h0101);
  endtask

  task automatic test_resume();
    cmd(1'b1, 1'b0, 1'b0);
    idle(6);
    fetch(16'h0100);
    cmd(1'b1, 1'b0, 1'b0);
    idle(8);
    fetch(16'h0102);
    fetch(16'h0100);
    cmd(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    bp_addr[31:16] = 16'h2000;
    bp_addr[63:48] = 16'h2000;
    bp_en = 4'b1010;
    fetch(16'h2000);
    cmd(1'b0, 1'b0, 1'b1);
    bp_en = 4'b0000;
    idle(3);
  endtask

  task automatic test_commands();
    cmd(1'b1, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1);
    idle(3);
    fetch(16'h3000);
    cmd(1'b1, 1'b0, 1'b0);
    fetch(16'h3001);
  endtask

  task automatic test_reset_mid_halt();
    cmd(1'b0, 1'b0, 1'b1);
    fetch(16'h4000);
    do_reset("reset_mid_halt");
  endtask

  task automatic test_wrap();
    bp_en = '0;
    for (int i = 0; i < 16; i++) fetch(16'(16'h5000 + i));
    vectors++;
    if (fetch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wrap: got %0d want 0", fetch_cnt);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        for (int i = 0; i < NUM_BP; i++) bp_addr[16*i +: 16] = 16'($urandom_range(0, 15));
        bp_en = 4'($urandom);
      end else if (m_held)
        cmd(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      else if (op < 3)
        cmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      else if (op == 3)
        idle($urandom_range(1, 5));
      else
        fetch(16'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_bp_hit();
    test_step();
    test_resume();
    test_priority();
    test_commands();
    test_reset_mid_halt();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/z80_breakpoint.md
# z80_breakpoint

Run-control companion to the Z80 register debugger: where the debugger passively samples CPU state on each opcode fetch, this block drives the CPU back by asserting the T80 `WAIT_n` input. It sits between the debug control registers and the T80pa core. It compares each opcode-fetch address against a set of breakpoints and freezes the CPU on a hit or on request. It also supports single-step and resume, and counts fetches.

## Interface
Parameters:
- `NUM_BP`, default 4: number of address breakpoints (1–8).
- `CNT_W`, default 32: width of the fetch counter.

Ports:
- `clk_sys`  in  1  system clock. One clock; reset is synchronous and active-low.
- `reset_n`  in  1  synchronous, active-low reset.
- `ce`  in  1  CPU clock enable, same as the T80pa `CEN`.
- `m1_n`  in  1  T80 M1 output, active low.
- `cpu_addr`  in  16  T80 address bus.
- `bp_addr`  in  NUM_BP×16  breakpoint addresses, packed; entry i is in `[16*i+15:16*i]`.
- `bp_en`  in  NUM_BP  per-breakpoint enable.
- `halt_req`  in  1  one-cycle pulse: stop at the next fetch.
- `step_req`  in  1  one-cycle pulse: execute one fetch, then stop.
- `run_req`  in  1  one-cycle pulse: resume free running.
- `wait_n`  out  1  to T80 `WAIT_n`, registered.
- `halted`  out  1  the CPU is held in a fetch.
- `hit_valid`  out  1  the current halt was caused by a breakpoint.
- `hit_idx`  out  3  lowest-numbered matching breakpoint.
- `halt_pc`  out  16  fetch address at which the CPU is held.
- `fetch_cnt`  out  CNT_W  count of M1 cycles since reset.

## Operation
- Fetch-start detection:
  - `m1_q` holds `m1_n` and is updated on `ce`.
  - `m1_fall = ce & ~m1_n & m1_q`.
  - Each prefix byte (CB/DD/ED/FD) counts as a separate fetch.
- Match:
  - `hit[i] = bp_en[i] & (cpu_addr == bp_addr[i])`, evaluated on `m1_fall`.
  - On multiple hits, `hit_idx` takes the lowest index.
- States: RUN, HALTED, STEP.
- RUN:
  - On `m1_fall` with any hit, or with `halt_pend` set: go to HALTED.
  - On that transition: `wait_n`←0, latch `halt_pc`←`cpu_addr`, set `hit_valid`←(any hit) and `hit_idx`.
  - `halt_pend` is set by `halt_req` in RUN or STEP and cleared on entering HALTED.
- HALTED:
  - `wait_n` is held at 0 and `halted`=1.
  - `run_req` → RUN; `wait_n`←1; clear `hit_valid`.
  - `step_req` → STEP; `wait_n`←1; clear `hit_valid`.
  - If both arrive together, `run_req` wins.
  - `halt_req` is ignored.
- STEP:
  - The next `m1_fall` → HALTED unconditionally. `hit_valid` reflects a breakpoint match at that address.
  - `run_req` → RUN.
- Resume from a breakpoint address does not re-trigger. The held M1 already passed its falling edge, so detection is edge-based.
- Breakpoint configuration changes take effect at the next `m1_fall`. They never release a HALTED CPU.
- `fetch_cnt`:
  - Increments on every `m1_fall` and wraps to 0 past all-ones.
  - It does not advance while halted, because no new edge occurs.

## Timing
- Reset values:
  - `wait_n`=1, `halted`=0, `hit_valid`=0, `hit_idx`=0, `halt_pc`=0, `fetch_cnt`=0.
  - State RUN, `halt_pend`=0, `m1_q`=1.
- Latency:
  - `wait_n` falls on the `clk_sys` edge following the `m1_fall` cycle. The T80 samples `WAIT_n` at T2, at least one `ce` later, so the fetch is stretched before completion.
  - `halted`, `halt_pc` and `hit_*` update on the same edge as `wait_n`.
- Release: `wait_n` rises on the edge after the `run_req` or `step_req` cycle.
- Reset mid-halt: `wait_n` rises on the first edge with `reset_n`=0.
- `ce` low: no state change except the command pulses. `run_req` and `step_req` are accepted on `clk_sys` regardless of `ce`.
- All outputs are registered. There is no combinational path from the inputs to `wait_n`.

## Structure
- Package `z80_dbg_pkg` holds:
  - the state enum `bp_state_t` (RUN, HALTED, STEP);
  - `MAX_BP`=8;
  - the shared Z80 flag-bit constants (carry 0, parity 2, zero 6, sign 7);
  - the register-bus field offsets used by the debugger blocks.
- Sub-module `z80_bp_match`: combinational comparator array plus priority encoder. Outputs are `any_hit` and `hit_idx`.
- Top level contains the FSM, edge detect, latches and counter.

## Test plan
- Breakpoint hit:
  - Stimulus: `bp_addr[0]`=0x0100, `bp_en`=0001, fetches at 0x00FE, 0x00FF, 0x0100.
  - Response: `wait_n`=0 one clock after the 0x0100 `m1_fall`; `halt_pc`=0x0100; `hit_valid`=1; `hit_idx`=0; `fetch_cnt`=3.
- Priority:
  - Stimulus: bp1 and bp3 both 0x2000, `bp_en`=1010, fetch 0x2000.
  - Response: `hit_idx`=1.
- Single step:
  - Stimulus: halted at 0x0100, `step_req`, CPU fetches 0x0101.
  - Response: `wait_n` rises next clock, re-falls after the 0x0101 `m1_fall`; `hit_valid`=0; `halt_pc`=0x0101.
- Resume without re-trigger:
  - Stimulus: halted on bp 0x0100, `run_req`.
  - Response: the CPU continues, no halt until 0x0100 is fetched again.
- Simultaneous commands and halt request:
  - Stimulus: `run_req` and `step_req` in the same cycle while HALTED.
  - Response: RUN.
  - Stimulus: `halt_req` in RUN with no breakpoints.
  - Response: halts at the next fetch with `hit_valid`=0.
- Reset mid-halt and counter wrap:
  - Stimulus: `reset_n`=0 while HALTED.
  - Response: `wait_n`=1, `halted`=0, `fetch_cnt`=0 on the next edge.
  - Stimulus: with `CNT_W`=4, 16 fetches.
  - Response: `fetch_cnt` wraps to 0.
